display_console: RTL and testbench
==================================

DISPLAY_CONSOLE -- requirements
Module: display_console

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning characters per row.
REQ-002 SHALL have parameter ROWS, default 30, meaning rows on screen (COLS*ROWS <= 4096).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-005 SHALL have port char_valid, input, 1 bit, meaning a character is offered.
REQ-006 SHALL have port char_data, input, 7 bits, meaning the offered 7-bit character code.
REQ-007 SHALL have port char_ready, output, 1 bit, meaning the block can accept a character this cycle.
REQ-008 SHALL have port write_enable, output, 1 bit, meaning the display buffer write strobe.
REQ-009 SHALL have port address, output, 12 bits, meaning the buffer cell index, row*COLS+col.
REQ-010 SHALL have port write_data, output, 7 bits, meaning the character code written to the buffer.
REQ-011 SHALL have port cursor_col, output, 7 bits, meaning the current cursor column.
REQ-012 SHALL have port cursor_row, output, 5 bits, meaning the current cursor row.

Function
REQ-013 SHALL accept a character on a cycle where char_valid and char_ready are both 1; char_ready SHALL be 1 exactly when the FSM is IDLE.
REQ-014 SHALL implement FSM states IDLE and CLEAR_LINE, plus CLEAR_SCREEN when the REQ-028 macro is defined.
REQ-015 SHALL register write_enable, address and write_data; a write caused by an accepted character appears in the cycle after acceptance, and write_enable is 1 for exactly one cycle per write.
REQ-016 Printable code (0x20-0x7E) SHALL write char_data at the current cursor position, then advance col by 1.
REQ-017 Printable code at col COLS-1 SHALL set col to 0 and advance the row.
REQ-018 LF (0x0A) SHALL set col to 0 and advance the row, with no character write.
REQ-019 CR (0x0D) SHALL set col to 0, with no write and no row change.
REQ-020 BS (0x08) with col>0 SHALL decrement col and write 0x20 at the new position; BS with col=0 SHALL be a no-op.
REQ-021 All other codes, including 0x7F, SHALL be accepted and ignored.
REQ-022 Row advance SHALL be row+1, wrapping from ROWS-1 to 0, and SHALL always enter CLEAR_LINE for the new row.
REQ-023 CLEAR_LINE SHALL write 0x20 to addresses newrow*COLS+0 through newrow*COLS+COLS-1, one per cycle, in the cycles immediately after any character write from the same acceptance, then return to IDLE.
REQ-024 char_ready SHALL therefore be low for exactly COLS cycles per row advance, and the cursor SHALL already show the new position during the clear.
REQ-025 row*COLS SHALL be computed at 12-bit width, giving a maximum address of 2399 at the defaults, with no truncation.
REQ-026 Back-to-back printable characters with no row advance SHALL sustain one character per cycle.

Reset
REQ-027 reset SHALL force, on the next clock edge and regardless of the current state (including mid-clear): FSM=IDLE, cursor_col=0, cursor_row=0, write_enable=0, address=0, write_data=0, and char_ready=1 from the following cycle; an in-progress clear SHALL be abandoned and buffer contents left untouched.

Configuration
REQ-028 When macro CONSOLE_CLEAR_SCREEN_EN is defined, FF (0x0C) SHALL enter CLEAR_SCREEN, write 0x20 to addresses 0 through COLS*ROWS-1 one per cycle with char_ready=0, then set the cursor to (0,0) and return to IDLE.
REQ-029 When macro CONSOLE_CLEAR_SCREEN_EN is undefined, FF SHALL be treated as an ignored code per REQ-021, and no CLEAR_SCREEN logic SHALL exist.

Verification
REQ-030 After reset, send 'A' (0x41): in the next cycle write_enable=1, address=0, write_data=0x41, and cursor_col becomes 1.
REQ-031 Cursor at (79,0), send 'Z': 'Z' is written at address 79, then addresses 80-159 are written with 0x20 over 80 cycles, char_ready is low for 80 cycles, and the cursor reads (0,1).
REQ-032 Cursor at row 29, send LF: addresses 0-79 are cleared and the cursor reads (0,0).
REQ-033 Cursor at (5,2), send BS: address 164 is written with 0x20 and cursor_col=4; then CR sets col=0 with no write.
REQ-034 Assert reset at clear write 40 of a CLEAR_LINE: no write occurs after reset, char_ready=1 the following cycle, and the cursor reads (0,0).
REQ-035 With CONSOLE_CLEAR_SCREEN_EN defined, send 0x0C: exactly 2400 writes of 0x20 occur to addresses 0-2399, then char_ready=1 and the cursor reads (0,0); with the macro undefined, 0x0C produces no write.

Source files
------------

// File: rtl/display_console.sv
// rtl/display_console.sv - character console writer; optional CLEAR_SCREEN on FF gated by CONSOLE_CLEAR_SCREEN_EN
module display_console #(
   parameter int COLS = 80,
   parameter int ROWS = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        char_valid,
   input  logic [6:0]  char_data,
   output logic        char_ready,
   output logic        write_enable,
   output logic [11:0] address,
   output logic [6:0]  write_data,
   output logic [6:0]  cursor_col,
   output logic [4:0]  cursor_row
);

   localparam logic [11:0] COLS_W    = 12'(COLS);
   localparam logic [6:0]  COL_LAST  = 7'(COLS - 1);
   localparam logic [4:0]  ROW_LAST  = 5'(ROWS - 1);
   localparam logic [11:0] LINE_LAST = 12'(COLS - 1);
`ifdef CONSOLE_CLEAR_SCREEN_EN
   localparam logic [11:0] SCREEN_LAST = 12'(COLS * ROWS - 1);
`endif
   localparam logic [6:0]  SPACE     = 7'h20;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CLEAR_LINE = 2'd1
`ifdef CONSOLE_CLEAR_SCREEN_EN
      ,
      CLEAR_SCREEN = 2'd2
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [6:0]  col_q, col_d;
   logic [4:0]  row_q, row_d;
   logic        we_q, we_d;
   logic [11:0] addr_q, addr_d;
   logic [6:0]  wdata_q, wdata_d;
   logic [11:0] idx_q, idx_d;
   logic [11:0] base_q, base_d;

   logic [11:0] cur_addr;
   logic [4:0]  row_inc;
   logic [11:0] row_inc_base;

   // Cursor cell address and the base of the row a row advance would land on.
   always_comb begin
      cur_addr     = 12'(row_q) * COLS_W + 12'(col_q);
      row_inc      = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
      row_inc_base = 12'(row_inc) * COLS_W;
   end

   assign char_ready   = (state_q == IDLE);
   assign write_enable = we_q;
   assign address      = addr_q;
   assign write_data   = wdata_q;
   assign cursor_col   = col_q;
   assign cursor_row   = row_q;

   // Next-state: decode accepted characters in IDLE, stream space writes while clearing.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      idx_d   = idx_q;
      base_d  = base_q;
      unique case (state_q)
         IDLE: begin
            if (char_valid) begin
               if (char_data >= 7'h20 && char_data <= 7'h7E) begin
                  we_d    = 1'b1;
                  addr_d  = cur_addr;
                  wdata_d = char_data;
                  if (col_q == COL_LAST) begin
                     col_d   = 7'd0;
                     row_d   = row_inc;
                     base_d  = row_inc_base;
                     idx_d   = 12'd0;
                     state_d = CLEAR_LINE;
                  end else begin
                     col_d = col_q + 7'd1;
                  end
               end else begin
                  case (char_data)
                     7'h0A: begin
                        col_d   = 7'd0;
                        row_d   = row_inc;
                        base_d  = row_inc_base;
                        idx_d   = 12'd0;
                        state_d = CLEAR_LINE;
                     end
                     7'h0D: col_d = 7'd0;
                     7'h08: begin
                        // Backspace at column 0 does nothing.
                        if (col_q != 7'd0) begin
                           col_d   = col_q - 7'd1;
                           we_d    = 1'b1;
                           addr_d  = cur_addr - 12'd1;
                           wdata_d = SPACE;
                        end
                     end
`ifdef CONSOLE_CLEAR_SCREEN_EN
                     7'h0C: begin
                        idx_d   = 12'd0;
                        state_d = CLEAR_SCREEN;
                     end
`endif
                     default: ;
                  endcase
               end
            end
         end
         CLEAR_LINE: begin
            we_d    = 1'b1;
            addr_d  = base_q + idx_q;
            wdata_d = SPACE;
            idx_d   = idx_q + 12'd1;
            if (idx_q == LINE_LAST) begin
               state_d = IDLE;
            end
         end
`ifdef CONSOLE_CLEAR_SCREEN_EN
         CLEAR_SCREEN: begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            wdata_d = SPACE;
            idx_d   = idx_q + 12'd1;
            if (idx_q == SCREEN_LAST) begin
               col_d   = 7'd0;
               row_d   = 5'd0;
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // State and registered write port; reset abandons any clear in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         col_q   <= 7'd0;
         row_q   <= 5'd0;
         we_q    <= 1'b0;
         addr_q  <= 12'd0;
         wdata_q <= 7'd0;
         idx_q   <= 12'd0;
         base_q  <= 12'd0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
      end
   end

endmodule

// File: tb/tb_display_console.sv
// tb/tb_display_console.sv - directed bench for display_console
module tb_display_console;

   logic        clk;
   logic        reset;
   logic        char_valid;
   logic [6:0]  char_data;
   logic        char_ready;
   logic        write_enable;
   logic [11:0] address;
   logic [6:0]  write_data;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;

   int compared;
   int mismatched;

   display_console #(.COLS(80), .ROWS(30)) dut (
      .clk          (clk),
      .reset        (reset),
      .char_valid   (char_valid),
      .char_data    (char_data),
      .char_ready   (char_ready),
      .write_enable (write_enable),
      .address      (address),
      .write_data   (write_data),
      .cursor_col   (cursor_col),
      .cursor_row   (cursor_row)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Wait (bounded) for char_ready, then offer one character for one edge.
   task automatic send(input logic [6:0] ch);
      int n;
      n = 0;
      while (char_ready !== 1'b1 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      compared++;
      if (char_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL send_ready: char_ready=%b required 1", char_ready);
      end
      char_valid = 1'b1;
      char_data  = ch;
      @(posedge clk); #1;
      char_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (char_ready !== 1'b1 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      compared++;
      if (char_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL wait_idle: char_ready=%b required 1", char_ready);
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      char_valid = 1'b0;
      char_data  = 7'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      compared++;
      if ({char_ready, write_enable, address, write_data, cursor_col, cursor_row} !== {1'b1, 1'b0, 12'd0, 7'd0, 7'd0, 5'd0}) begin
         mismatched++;
         $display("FAIL reset_state: rdy=%b we=%b addr=%0d wd=%h col=%0d row=%0d required 1 0 0 00 0 0",
                  char_ready, write_enable, address, write_data, cursor_col, cursor_row);
      end
   endtask

   task automatic test_printable();
      send(7'h41);
      compared++;
      if ({write_enable, address, write_data, cursor_col} !== {1'b1, 12'd0, 7'h41, 7'd1}) begin
         mismatched++;
         $display("FAIL print_A: we=%b addr=%0d wd=%h col=%0d required 1 0 41 1",
                  write_enable, address, write_data, cursor_col);
      end
      @(posedge clk); #1;
      compared++;
      if (write_enable !== 1'b0) begin
         mismatched++;
         $display("FAIL we_pulse: we=%b required 0", write_enable);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] code;
      char_valid = 1'b1;
      for (int i = 0; i < 78; i++) begin
         code      = 7'h61 + 7'(i % 26);
         char_data = code;
         compared++;
         if (char_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_ready[%0d]: rdy=%b required 1", i, char_ready);
         end
         @(posedge clk); #1;
         compared++;
         if ({write_enable, address, write_data} !== {1'b1, 12'(i + 1), code}) begin
            mismatched++;
            $display("FAIL b2b_write[%0d]: we=%b addr=%0d wd=%h required 1 %0d %h",
                     i, write_enable, address, write_data, i + 1, code);
         end
      end
      char_valid = 1'b0;
      compared++;
      if ({cursor_col, cursor_row} !== {7'd79, 5'd0}) begin
         mismatched++;
         $display("FAIL b2b_cursor: col=%0d row=%0d required 79 0", cursor_col, cursor_row);
      end
   endtask

   task automatic test_line_wrap();
      int low_cnt;
      int errs;
      send(7'h5A);
      compared++;
      if ({write_enable, address, write_data, cursor_col, cursor_row} !== {1'b1, 12'd79, 7'h5A, 7'd0, 5'd1}) begin
         mismatched++;
         $display("FAIL wrap_Z: we=%b addr=%0d wd=%h col=%0d row=%0d required 1 79 5a 0 1",
                  write_enable, address, write_data, cursor_col, cursor_row);
      end
      low_cnt = (char_ready === 1'b0) ? 1 : 0;
      errs    = 0;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         if ({write_enable, address, write_data} !== {1'b1, 12'(80 + k), 7'h20}) errs++;
         if (char_ready === 1'b0) low_cnt++;
      end
      compared++;
      if (errs != 0) begin
         mismatched++;
         $display("FAIL wrap_clear: bad clear writes=%0d required 0", errs);
      end
      compared++;
      if (low_cnt != 80) begin
         mismatched++;
         $display("FAIL wrap_ready_low: low cycles=%0d required 80", low_cnt);
      end
      @(posedge clk); #1;
      compared++;
      if ({write_enable, char_ready} !== 2'b01) begin
         mismatched++;
         $display("FAIL wrap_end: we=%b rdy=%b required 0 1", write_enable, char_ready);
      end
   endtask

   task automatic test_bs_cr();
      send(7'h0A);
      wait_idle();
      send(7'h68); send(7'h65); send(7'h6C); send(7'h6C); send(7'h6F);
      compared++;
      if ({cursor_col, cursor_row} !== {7'd5, 5'd2}) begin
         mismatched++;
         $display("FAIL bs_setup: col=%0d row=%0d required 5 2", cursor_col, cursor_row);
      end
      send(7'h08);
      compared++;
      if ({write_enable, address, write_data, cursor_col} !== {1'b1, 12'd164, 7'h20, 7'd4}) begin
         mismatched++;
         $display("FAIL bs: we=%b addr=%0d wd=%h col=%0d required 1 164 20 4",
                  write_enable, address, write_data, cursor_col);
      end
      send(7'h0D);
      compared++;
      if ({write_enable, cursor_col, cursor_row, char_ready} !== {1'b0, 7'd0, 5'd2, 1'b1}) begin
         mismatched++;
         $display("FAIL cr: we=%b col=%0d row=%0d rdy=%b required 0 0 2 1",
                  write_enable, cursor_col, cursor_row, char_ready);
      end
      send(7'h08);
      compared++;
      if ({write_enable, cursor_col} !== {1'b0, 7'd0}) begin
         mismatched++;
         $display("FAIL bs_col0: we=%b col=%0d required 0 0", write_enable, cursor_col);
      end
      send(7'h7F);
      compared++;
      if ({write_enable, cursor_col, cursor_row, char_ready} !== {1'b0, 7'd0, 5'd2, 1'b1}) begin
         mismatched++;
         $display("FAIL del_ignored: we=%b col=%0d row=%0d rdy=%b required 0 0 2 1",
                  write_enable, cursor_col, cursor_row, char_ready);
      end
   endtask

   task automatic test_row_wrap();
      int errs;
      for (int i = 0; i < 27; i++) send(7'h0A);
      wait_idle();
      compared++;
      if ({cursor_col, cursor_row} !== {7'd0, 5'd29}) begin
         mismatched++;
         $display("FAIL row29_setup: col=%0d row=%0d required 0 29", cursor_col, cursor_row);
      end
      send(7'h0A);
      compared++;
      if ({write_enable, cursor_col, cursor_row, char_ready} !== {1'b0, 7'd0, 5'd0, 1'b0}) begin
         mismatched++;
         $display("FAIL row_wrap_lf: we=%b col=%0d row=%0d rdy=%b required 0 0 0 0",
                  write_enable, cursor_col, cursor_row, char_ready);
      end
      errs = 0;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         if ({write_enable, address, write_data} !== {1'b1, 12'(k), 7'h20}) errs++;
      end
      compared++;
      if (errs != 0) begin
         mismatched++;
         $display("FAIL row_wrap_clear: bad clear writes=%0d required 0", errs);
      end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      int errs;
      send(7'h0A);
      n = 0;
      while (!(write_enable === 1'b1 && address === 12'd119) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      compared++;
      if (address !== 12'd119) begin
         mismatched++;
         $display("FAIL mid_clear_reach: addr=%0d required 119", address);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      compared++;
      if ({char_ready, write_enable, address, write_data, cursor_col, cursor_row} !== {1'b1, 1'b0, 12'd0, 7'd0, 7'd0, 5'd0}) begin
         mismatched++;
         $display("FAIL mid_clear_reset: rdy=%b we=%b addr=%0d wd=%h col=%0d row=%0d required 1 0 0 00 0 0",
                  char_ready, write_enable, address, write_data, cursor_col, cursor_row);
      end
      errs = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (write_enable !== 1'b0 || char_ready !== 1'b1) errs++;
      end
      compared++;
      if (errs != 0) begin
         mismatched++;
         $display("FAIL mid_clear_quiet: cycles with write or not ready=%0d required 0", errs);
      end
   endtask

   task automatic test_form_feed();
`ifdef CONSOLE_CLEAR_SCREEN_EN
      int cnt;
      int errs;
      int n;
      send(7'h03);
      send(7'h0C);
      cnt  = 0;
      errs = 0;
      n    = 0;
      while (n < 2600) begin
         if (write_enable === 1'b1) begin
            if (address !== 12'(cnt) || write_data !== 7'h20) errs++;
            cnt++;
         end
         if (char_ready === 1'b1) break;
         @(posedge clk); #1;
         n++;
      end
      compared++;
      if (cnt != 2400 || errs != 0) begin
         mismatched++;
         $display("FAIL clear_screen: writes=%0d bad=%0d required 2400 0", cnt, errs);
      end
      compared++;
      if ({char_ready, cursor_col, cursor_row} !== {1'b1, 7'd0, 5'd0}) begin
         mismatched++;
         $display("FAIL clear_screen_end: rdy=%b col=%0d row=%0d required 1 0 0",
                  char_ready, cursor_col, cursor_row);
      end
`else
      send(7'h41);
      send(7'h0C);
      compared++;
      if ({write_enable, char_ready, cursor_col, cursor_row} !== {1'b0, 1'b1, 7'd1, 5'd0}) begin
         mismatched++;
         $display("FAIL ff_ignored: we=%b rdy=%b col=%0d row=%0d required 0 1 1 0",
                  write_enable, char_ready, cursor_col, cursor_row);
      end
`endif
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_printable();
      test_back_to_back();
      test_line_wrap();
      test_bs_cr();
      test_row_wrap();
      test_reset_mid_clear();
      test_form_feed();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
